// File: rtl/window_gen_3x3_pkg.sv
// Shared types and constants for the 3x3 window generator and the median sorter it feeds.
package window_gen_3x3_pkg;

  localparam int unsigned SIZE     = 8;
  localparam int unsigned NUM_VALS = 9;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StRun
  } state_e;

endpackage

// File: rtl/window_gen_3x3_if.sv
// Pixel-stream in / window-stream out bundle for window_gen_3x3.
interface window_gen_3x3_if #(
  parameter int unsigned SIZE     = window_gen_3x3_pkg::SIZE,
  parameter int unsigned NUM_VALS = window_gen_3x3_pkg::NUM_VALS
);

  logic                     sof;
  logic                     pix_valid;
  logic [SIZE-1:0]          pix_in;
  logic                     win_valid;
  logic [NUM_VALS*SIZE-1:0] win_out;
  logic                     frame_done;

  modport master (
    output sof, pix_valid, pix_in,
    input  win_valid, win_out, frame_done
  );

  modport slave (
    input  sof, pix_valid, pix_in,
    output win_valid, win_out, frame_done
  );

endinterface

// File: rtl/window_gen_3x3_line_buffer.sv
// Single-port line RAM: read-before-write at one address, registered read data.
module line_buffer #(
  parameter int unsigned Depth = 640,
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic             rd_en_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [Width-1:0] wr_data_i,
  output logic [Width-1:0] rd_data_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] rd_data_q, rd_data_d;

  // Read data holds between accesses so the window output stays stable.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) rd_data_d = mem_q[addr_i];
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[addr_i] <= wr_data_i;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/window_gen_3x3.sv
// Raster-stream 3x3 window generator: two ping-pong line buffers plus a column shift window.
module window_gen_3x3 #(
  parameter int unsigned SIZE     = window_gen_3x3_pkg::SIZE,
  parameter int unsigned IMG_W    = 640,
  parameter int unsigned IMG_H    = 480,
  parameter int unsigned NUM_VALS = window_gen_3x3_pkg::NUM_VALS
) (
  input  logic            clk,
  input  logic            rst,
  window_gen_3x3_if.slave bus
);

  import window_gen_3x3_pkg::*;

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);

  state_e          state_q, state_d;
  logic [CW-1:0]   col_q, col_d, cur_col;
  logic [RW-1:0]   row_q, row_d, cur_row;
  logic            restart, accept, last_pix;

  logic [SIZE-1:0] win_q [3][2];
  logic [SIZE-1:0] win_d [3][2];
  logic [SIZE-1:0] pix_q, pix_d;
  logic            sel_q, sel_d;
  logic            win_valid_q, win_valid_d;
  logic            frame_done_q, frame_done_d;

  logic [SIZE-1:0] lb_rd [2];
  logic [1:0]      lb_we;
  logic [SIZE-1:0] col2 [3];
  logic [NUM_VALS*SIZE-1:0] win_flat;

  assign restart  = bus.pix_valid & bus.sof;
  assign accept   = bus.pix_valid & (bus.sof | (state_q != StIdle));
  assign cur_col  = restart ? '0 : col_q;
  assign cur_row  = restart ? '0 : row_q;
  assign last_pix = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));

  // Row parity picks the buffer to overwrite; its read-before-write output is row-2.
  assign lb_we[0] = accept & ~cur_row[0];
  assign lb_we[1] = accept &  cur_row[0];

  line_buffer #(
    .Depth (IMG_W),
    .Width (SIZE),
    .AddrW (CW)
  ) u_lb0 (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (lb_we[0]),
    .rd_en_i   (accept),
    .addr_i    (cur_col),
    .wr_data_i (bus.pix_in),
    .rd_data_o (lb_rd[0])
  );

  line_buffer #(
    .Depth (IMG_W),
    .Width (SIZE),
    .AddrW (CW)
  ) u_lb1 (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (lb_we[1]),
    .rd_en_i   (accept),
    .addr_i    (cur_col),
    .wr_data_i (bus.pix_in),
    .rd_data_o (lb_rd[1])
  );

  // Newest column comes straight from the RAM read registers and the pixel register.
  always_comb begin
    col2[0] = lb_rd[sel_q];
    col2[1] = lb_rd[~sel_q];
    col2[2] = pix_q;
  end

  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = StFill;
    end else if (accept) begin
      case (state_q)
        StFill: if (cur_row == RW'(2) && cur_col == '0) state_d = StRun;
        StRun:  if (last_pix) state_d = StIdle;
        default: ;
      endcase
    end
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (last_pix) begin
        col_d = '0;
        row_d = '0;
      end else if (cur_col == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  always_comb begin
    win_d = win_q;
    pix_d = pix_q;
    sel_d = sel_q;
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = col2[r];
      end
      pix_d = bus.pix_in;
      sel_d = cur_row[0];
    end
    win_valid_d  = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    frame_done_d = accept && last_pix;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '{default: '0};
      pix_q        <= '0;
      sel_q        <= 1'b0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      pix_q        <= pix_d;
      sel_q        <= sel_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    win_flat = '0;
    for (int r = 0; r < 3; r++) begin
      win_flat[(r*3)*SIZE   +: SIZE] = win_q[r][0];
      win_flat[(r*3+1)*SIZE +: SIZE] = win_q[r][1];
      win_flat[(r*3+2)*SIZE +: SIZE] = col2[r];
    end
  end

  assign bus.win_out    = win_flat;
  assign bus.win_valid  = win_valid_q;
  assign bus.frame_done = frame_done_q;

endmodule
